me_search_feeder: RTL and testbench

- Drives the systolic SAD array built from `pe` cells during integer motion estimation.
- Fetches search-window and current-block pixels from the on-chip window buffer.
- Emits per-cycle shift select plus edge pixels so the array walks every candidate position in snake order.
- Tags each candidate with its (x,y) offset for the downstream SAD accumulator / best-MV selector.

---
 rtl/me_search_feeder.sv | 203 ++++++++++++++++++++
 tb/tb_me_search_feeder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_search_feeder.sv
// Feeds a BLK x BLK systolic SAD array: fetches window/current-block segments and
// walks every candidate offset in snake order, tagging each completed position.
module me_search_feeder #(
   parameter int PIX_WIDTH = 8,
   parameter int BLK       = 4,
   parameter int RANGE     = 2,
   parameter int CW        = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              hold,
   output logic                              busy,
   output logic                              done,
   output logic                              sw_rd_en,
   output logic [CW-1:0]                     sw_rd_x,
   output logic [CW-1:0]                     sw_rd_y,
   output logic                              sw_rd_col,
   input  logic [BLK*PIX_WIDTH-1:0]          sw_rdata,
   output logic                              cur_rd_en,
   output logic [((BLK>1)?$clog2(BLK):1)-1:0] cur_rd_row,
   input  logic [BLK*PIX_WIDTH-1:0]          cur_rdata,
   output logic [1:0]                        pe_sel,
   output logic                              pe_shift_en,
   output logic [BLK*PIX_WIDTH-1:0]          edge_pix,
   output logic [BLK*PIX_WIDTH-1:0]          cur_row,
   output logic                              cur_shift_en,
   output logic                              cand_valid,
   output logic [CW-1:0]                     cand_x,
   output logic [CW-1:0]                     cand_y
);

   localparam int NC = 2*RANGE + 1;
   localparam int DW = BLK*PIX_WIDTH;
   localparam int RW = (BLK > 1) ? $clog2(BLK) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DRAIN} state_t;

   // Everything the response cycle needs to know about an issued read.
   typedef struct packed {
      logic [1:0]    sel;
      logic          has_cur;
      logic          completes;
      logic [CW-1:0] cx;
      logic [CW-1:0] cy;
   } tag_t;

   state_t        state_reg, state_next;
   logic [RW-1:0] ld_row_reg, ld_row_next;
   logic [CW-1:0] pos_x_reg, pos_x_next;
   logic [CW-1:0] pos_y_reg, pos_y_next;
   tag_t          issue_tag;

   logic          resp_vld_reg;
   tag_t          resp_tag_reg;
   logic          pend_vld_reg;
   tag_t          pend_tag_reg;
   logic [DW-1:0] pend_sw_reg;
   logic [DW-1:0] pend_cur_reg;
   logic          cand_due_reg;
   logic [CW-1:0] cand_x_reg;
   logic [CW-1:0] cand_y_reg;

   logic          mv_down, mv_up;
   logic          shift_fire;
   tag_t          shift_tag;
   logic [DW-1:0] shift_sw;
   logic [DW-1:0] shift_cur;

   // Even columns walk down, odd columns walk up; otherwise step right.
   assign mv_down = ~pos_x_reg[0] && (pos_y_reg != CW'(NC-1));
   assign mv_up   =  pos_x_reg[0] && (pos_y_reg != '0);

   always_comb begin
      state_next  = state_reg;
      ld_row_next = ld_row_reg;
      pos_x_next  = pos_x_reg;
      pos_y_next  = pos_y_reg;
      issue_tag   = '0;
      sw_rd_en    = 1'b0;
      sw_rd_x     = '0;
      sw_rd_y     = '0;
      sw_rd_col   = 1'b0;
      cur_rd_en   = 1'b0;
      cur_rd_row  = '0;
      done        = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next  = S_LOAD;
               ld_row_next = '0;
               pos_x_next  = '0;
               pos_y_next  = '0;
            end
         end
         S_LOAD: begin
            if (!hold) begin
               sw_rd_en            = 1'b1;
               sw_rd_y             = CW'(ld_row_reg);
               cur_rd_en           = 1'b1;
               cur_rd_row          = ld_row_reg;
               issue_tag.sel       = 2'b01;
               issue_tag.has_cur   = 1'b1;
               issue_tag.completes = (ld_row_reg == RW'(BLK-1));
               ld_row_next         = ld_row_reg + RW'(1);
               if (ld_row_reg == RW'(BLK-1))
                  state_next = (NC > 1) ? S_SCAN : S_DRAIN;
            end
         end
         S_SCAN: begin
            if (!hold) begin
               sw_rd_en            = 1'b1;
               sw_rd_x             = pos_x_reg;
               sw_rd_y             = pos_y_reg;
               issue_tag.completes = 1'b1;
               if (mv_down) begin
                  sw_rd_y       = pos_y_reg + CW'(BLK);
                  issue_tag.sel = 2'b01;
                  pos_y_next    = pos_y_reg + CW'(1);
               end else if (mv_up) begin
                  sw_rd_y       = pos_y_reg - CW'(1);
                  issue_tag.sel = 2'b00;
                  pos_y_next    = pos_y_reg - CW'(1);
               end else begin
                  sw_rd_x       = pos_x_reg + CW'(BLK);
                  sw_rd_col     = 1'b1;
                  issue_tag.sel = 2'b10;
                  pos_x_next    = pos_x_reg + CW'(1);
               end
               issue_tag.cx = pos_x_next;
               issue_tag.cy = pos_y_next;
               if (pos_x_next == CW'(NC-1) && pos_y_next == CW'(NC-1))
                  state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!hold && !resp_vld_reg && !pend_vld_reg && !cand_due_reg) begin
               done       = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Response side: a parked (held) response always goes before fresh data.
   always_comb begin
      shift_tag    = pend_vld_reg ? pend_tag_reg : resp_tag_reg;
      shift_sw     = pend_vld_reg ? pend_sw_reg  : sw_rdata;
      shift_cur    = pend_vld_reg ? pend_cur_reg : cur_rdata;
      shift_fire   = (pend_vld_reg || resp_vld_reg) && !hold;
      pe_shift_en  = shift_fire;
      pe_sel       = shift_fire ? shift_tag.sel : 2'b11;
      edge_pix     = shift_fire ? shift_sw : '0;
      cur_shift_en = shift_fire && shift_tag.has_cur;
      cur_row      = cur_shift_en ? shift_cur : '0;
      cand_valid   = cand_due_reg && !hold;
      cand_x       = cand_valid ? cand_x_reg : '0;
      cand_y       = cand_valid ? cand_y_reg : '0;
      busy         = (state_reg != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg    <= S_IDLE;
         ld_row_reg   <= '0;
         pos_x_reg    <= '0;
         pos_y_reg    <= '0;
         resp_vld_reg <= 1'b0;
         resp_tag_reg <= '0;
         pend_vld_reg <= 1'b0;
         pend_tag_reg <= '0;
         pend_sw_reg  <= '0;
         pend_cur_reg <= '0;
         cand_due_reg <= 1'b0;
         cand_x_reg   <= '0;
         cand_y_reg   <= '0;
      end else begin
         state_reg    <= state_next;
         ld_row_reg   <= ld_row_next;
         pos_x_reg    <= pos_x_next;
         pos_y_reg    <= pos_y_next;
         resp_vld_reg <= sw_rd_en;
         resp_tag_reg <= issue_tag;
         if (hold && resp_vld_reg) begin
            pend_vld_reg <= 1'b1;
            pend_tag_reg <= resp_tag_reg;
            pend_sw_reg  <= sw_rdata;
            pend_cur_reg <= cur_rdata;
         end else if (!hold) begin
            pend_vld_reg <= 1'b0;
         end
         if (shift_fire && shift_tag.completes) begin
            cand_due_reg <= 1'b1;
            cand_x_reg   <= shift_tag.cx;
            cand_y_reg   <= shift_tag.cy;
         end else if (cand_valid) begin
            cand_due_reg <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_me_search_feeder.sv
// Scoreboard bench for me_search_feeder: expected reads, shifts and candidates are
// queued per run and popped by a negedge monitor; a golden array model checks SAD.
module tb_me_search_feeder;
   localparam int PW = 8, BLK = 4, RANGE = 2, CW = 4, NC = 5, DW = BLK*PW;
   localparam logic [1:0] SEL_TAB [28] = '{
      2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
      2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
      2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};

   logic clk = 1'b0, rst = 1'b0, start = 1'b0, hold = 1'b0;
   logic busy, done, sw_rd_en, sw_rd_col, cur_rd_en;
   logic [CW-1:0] sw_rd_x, sw_rd_y, cand_x, cand_y;
   logic [DW-1:0] sw_rdata = '0, cur_rdata = '0, edge_pix, cur_row;
   logic [1:0] cur_rd_row, pe_sel;
   logic pe_shift_en, cur_shift_en, cand_valid;

   me_search_feeder #(.PIX_WIDTH(PW), .BLK(BLK), .RANGE(RANGE), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done),
      .sw_rd_en(sw_rd_en), .sw_rd_x(sw_rd_x), .sw_rd_y(sw_rd_y), .sw_rd_col(sw_rd_col),
      .sw_rdata(sw_rdata), .cur_rd_en(cur_rd_en), .cur_rd_row(cur_rd_row),
      .cur_rdata(cur_rdata), .pe_sel(pe_sel), .pe_shift_en(pe_shift_en),
      .edge_pix(edge_pix), .cur_row(cur_row), .cur_shift_en(cur_shift_en),
      .cand_valid(cand_valid), .cand_x(cand_x), .cand_y(cand_y));

   always #5 clk = ~clk;

   typedef struct { logic [1:0] sel; logic [DW-1:0] epix; logic cur_en; logic [DW-1:0] cur; } shift_t;
   typedef struct { int x; int y; logic col; logic cur_en; int row; } rd_t;
   typedef struct { int x; int y; } cand_t;

   shift_t exp_shift_q[$];
   rd_t    exp_rd_q[$];
   cand_t  exp_cand_q[$];

   int checks = 0, errors = 0;
   int cyc = 0, start_cyc = 0, exp_done_rel = 0;
   int done_cnt = 0, cand_cnt = 0, sh_idx = 0;
   int first_rd = -1, last_rd = -1, first_cand = -1, last_cand = -1;
   logic mon_en = 1'b0;
   logic [7:0] arr [BLK][BLK];

   function automatic logic [7:0] win(int x, int y);
      return 8'(16*y + x);
   endfunction

   function automatic logic [7:0] cur_px(int r, int c);
      return win(3 + c, 1 + r);   // current block planted at candidate (3,1)
   endfunction

   function automatic logic [DW-1:0] seg(int x, int y, logic col);
      logic [DW-1:0] v;
      for (int k = 0; k < BLK; k++) v[k*PW +: PW] = col ? win(x, y + k) : win(x + k, y);
      return v;
   endfunction

   function automatic logic [DW-1:0] cur_line(int r);
      logic [DW-1:0] v;
      for (int c = 0; c < BLK; c++) v[c*PW +: PW] = cur_px(r, c);
      return v;
   endfunction

   task automatic chk(input bit ok, input string nm, input string got, input string want);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %s, want %s", nm, got, want);
      end
   endtask

   // Window and current-block buffers, one-cycle read latency.
   always @(posedge clk) begin
      if (sw_rd_en) sw_rdata <= seg(int'(sw_rd_x), int'(sw_rd_y), sw_rd_col);
      if (cur_rd_en) cur_rdata <= cur_line(int'(cur_rd_row));
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic push_rd(input int x, input int y, input logic col, input logic ce, input int row);
      rd_t e;
      e.x = x; e.y = y; e.col = col; e.cur_en = ce; e.row = row;
      exp_rd_q.push_back(e);
   endtask

   task automatic push_shift(input logic [1:0] sel, input logic [DW-1:0] p, input logic ce, input logic [DW-1:0] cl);
      shift_t e;
      e.sel = sel; e.epix = p; e.cur_en = ce; e.cur = cl;
      exp_shift_q.push_back(e);
   endtask

   task automatic push_cand(input int x, input int y);
      cand_t e;
      e.x = x; e.y = y;
      exp_cand_q.push_back(e);
   endtask

   task automatic build_expected();
      int px[$], py[$];
      exp_rd_q.delete(); exp_shift_q.delete(); exp_cand_q.delete();
      for (int r = 0; r < BLK; r++) begin
         push_rd(0, r, 1'b0, 1'b1, r);
         push_shift(2'b01, seg(0, r, 1'b0), 1'b1, cur_line(r));
      end
      push_cand(0, 0);
      for (int x = 0; x < NC; x++)
         for (int k = 0; k < NC; k++) begin
            px.push_back(x);
            py.push_back((x % 2 == 0) ? k : NC - 1 - k);
         end
      for (int i = 1; i < px.size(); i++) begin
         if (px[i] > px[i-1]) begin
            push_rd(px[i-1] + BLK, py[i-1], 1'b1, 1'b0, 0);
            push_shift(2'b10, seg(px[i-1] + BLK, py[i-1], 1'b1), 1'b0, '0);
         end else if (py[i] > py[i-1]) begin
            push_rd(px[i-1], py[i-1] + BLK, 1'b0, 1'b0, 0);
            push_shift(2'b01, seg(px[i-1], py[i-1] + BLK, 1'b0), 1'b0, '0);
         end else begin
            push_rd(px[i-1], py[i-1] - 1, 1'b0, 1'b0, 0);
            push_shift(2'b00, seg(px[i-1], py[i-1] - 1, 1'b0), 1'b0, '0);
         end
         push_cand(px[i], py[i]);
      end
   endtask

   // Monitor: pops and compares whenever the DUT presents a read, shift, candidate or done.
   initial forever begin
      int rel, sad;
      rd_t r; shift_t s; cand_t c;
      @(negedge clk);
      rel = cyc - start_cyc;
      if (mon_en) begin
         if (sw_rd_en || cur_rd_en) begin
            if (first_rd < 0) first_rd = rel;
            last_rd = rel;
            if (exp_rd_q.size() == 0) chk(1'b0, "rd_extra", $sformatf("read at rel %0d", rel), "none");
            else begin
               r = exp_rd_q.pop_front();
               chk(sw_rd_en && int'(sw_rd_x) == r.x && int'(sw_rd_y) == r.y && sw_rd_col == r.col &&
                   cur_rd_en == r.cur_en && (!r.cur_en || int'(cur_rd_row) == r.row), "rd",
                   $sformatf("en=%0b x=%0d y=%0d col=%0b cen=%0b row=%0d", sw_rd_en, sw_rd_x, sw_rd_y, sw_rd_col, cur_rd_en, cur_rd_row),
                   $sformatf("en=1 x=%0d y=%0d col=%0b cen=%0b row=%0d", r.x, r.y, r.col, r.cur_en, r.row));
            end
         end
         if (cand_valid) begin
            if (first_cand < 0) first_cand = rel;
            last_cand = rel;
            cand_cnt++;
            sad = 0;
            for (int i = 0; i < BLK; i++)
               for (int j = 0; j < BLK; j++)
                  sad += (arr[i][j] > cur_px(i, j)) ? int'(arr[i][j] - cur_px(i, j)) : int'(cur_px(i, j) - arr[i][j]);
            if (exp_cand_q.size() == 0) chk(1'b0, "cand_extra", $sformatf("cand at rel %0d", rel), "none");
            else begin
               c = exp_cand_q.pop_front();
               chk(int'(cand_x) == c.x && int'(cand_y) == c.y, "cand_xy",
                   $sformatf("(%0d,%0d)", cand_x, cand_y), $sformatf("(%0d,%0d)", c.x, c.y));
               chk((sad == 0) == (c.x == 3 && c.y == 1), "sad",
                   $sformatf("sad=%0d at (%0d,%0d)", sad, c.x, c.y), "zero only at (3,1)");
            end
         end
         if (pe_shift_en) begin
            if (sh_idx < 28) chk(pe_sel == SEL_TAB[sh_idx], "sel_table",
               $sformatf("shift %0d sel=%0b", sh_idx, pe_sel), $sformatf("%0b", SEL_TAB[sh_idx]));
            sh_idx++;
            if (exp_shift_q.size() == 0) chk(1'b0, "shift_extra", $sformatf("shift at rel %0d", rel), "none");
            else begin
               s = exp_shift_q.pop_front();
               chk(pe_sel == s.sel && edge_pix == s.epix && cur_shift_en == s.cur_en && cur_row == s.cur, "shift",
                   $sformatf("sel=%0b edge=%h cen=%0b cur=%h", pe_sel, edge_pix, cur_shift_en, cur_row),
                   $sformatf("sel=%0b edge=%h cen=%0b cur=%h", s.sel, s.epix, s.cur_en, s.cur));
            end
            case (pe_sel)
               2'b01: begin
                  for (int i = 0; i < BLK - 1; i++) arr[i] = arr[i+1];
                  for (int k = 0; k < BLK; k++) arr[BLK-1][k] = edge_pix[k*PW +: PW];
               end
               2'b00: begin
                  for (int i = BLK - 1; i > 0; i--) arr[i] = arr[i-1];
                  for (int k = 0; k < BLK; k++) arr[0][k] = edge_pix[k*PW +: PW];
               end
               2'b10: begin
                  for (int i = 0; i < BLK; i++) begin
                     for (int j = 0; j < BLK - 1; j++) arr[i][j] = arr[i][j+1];
                     arr[i][BLK-1] = edge_pix[i*PW +: PW];
                  end
               end
               default: ;
            endcase
         end else begin
            chk(pe_sel == 2'b11 && edge_pix == '0 && !cur_shift_en, "idle_sel",
                $sformatf("sel=%0b edge=%h cen=%0b", pe_sel, edge_pix, cur_shift_en), "sel=11 edge=0 cen=0");
         end
         if (done) begin
            done_cnt++;
            chk(rel == exp_done_rel, "done_cycle", $sformatf("%0d", rel), $sformatf("%0d", exp_done_rel));
         end
      end
   end

   task automatic check_idle(input string nm);
      chk(!busy && !done && !sw_rd_en && !cur_rd_en && !pe_shift_en && !cur_shift_en && !cand_valid &&
          pe_sel == 2'b11 && sw_rd_x == '0 && sw_rd_y == '0 && !sw_rd_col && cur_rd_row == '0 &&
          edge_pix == '0 && cur_row == '0 && cand_x == '0 && cand_y == '0, nm,
          $sformatf("busy=%0b done=%0b rd=%0b/%0b sh=%0b sel=%0b cv=%0b", busy, done, sw_rd_en, cur_rd_en, pe_shift_en, pe_sel, cand_valid),
          "all idle, sel=11");
   endtask

   // One accepted start; hold in [ha, ha+hlen) and at hb; optional abort at abort_at.
   task automatic run(input int ha, input int hlen, input int hb, input int exp_done,
                      input bit extra_starts, input int abort_at, input bit timing);
      build_expected();
      done_cnt = 0; cand_cnt = 0; sh_idx = 0;
      first_rd = -1; last_rd = -1; first_cand = -1; last_cand = -1;
      exp_done_rel = exp_done;
      @(posedge clk); #1;
      start_cyc = cyc;
      start = 1'b1;
      hold = (ha == 0 && hlen > 0);
      mon_en = 1'b1;
      for (int c = 1; c < 80; c++) begin
         @(posedge clk); #1;
         start = extra_starts && (c == 10 || c == 20);
         hold = (c >= ha && c < ha + hlen) || (c == hb);
         rst = (c != abort_at);
         if (abort_at > 0 && c == abort_at + 1) break;
         if (abort_at == 0 && done_cnt != 0 && c > exp_done + 3) break;
      end
      start = 1'b0; hold = 1'b0;
      if (abort_at > 0) begin
         @(negedge clk);
         check_idle("abort_reset_state");
         repeat (6) @(negedge clk);
         chk(done_cnt == 0 && !busy, "abort_no_done", $sformatf("done_cnt=%0d busy=%0b", done_cnt, busy), "0,0");
         mon_en = 1'b0;
         exp_rd_q.delete(); exp_shift_q.delete(); exp_cand_q.delete();
      end else begin
         chk(done_cnt == 1, "done_count", $sformatf("%0d", done_cnt), "1");
         chk(cand_cnt == 25, "cand_count", $sformatf("%0d", cand_cnt), "25");
         chk(exp_rd_q.size() == 0 && exp_shift_q.size() == 0 && exp_cand_q.size() == 0, "queues_drained",
             $sformatf("rd=%0d sh=%0d cand=%0d", exp_rd_q.size(), exp_shift_q.size(), exp_cand_q.size()), "0,0,0");
         if (timing)
            chk(first_rd == 1 && last_rd == 28 && first_cand == 6 && last_cand == 30, "timing",
                $sformatf("rd %0d..%0d cand %0d..%0d", first_rd, last_rd, first_cand, last_cand), "rd 1..28 cand 6..30");
         @(negedge clk);
         check_idle("post_run_idle");
         mon_en = 1'b0;
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle("reset_state");
      @(posedge clk); #1;
      rst = 1'b1;
      hold = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_idle("hold_in_idle");
      end
      @(posedge clk); #1;
      hold = 1'b0;
      run(-1, 0, -1, 31, 1'b1, 0, 1'b1);   // clean run with ignored start pulses
      run(10, 3, 20, 35, 1'b0, 0, 1'b0);   // 3+1 hold cycles
      run(0, 3, -1, 33, 1'b0, 0, 1'b0);    // start with hold; only post-start hold cycles count
      run(-1, 0, -1, 31, 1'b0, 15, 1'b0);  // reset mid-SCAN
      run(-1, 0, -1, 31, 1'b0, 0, 1'b1);   // clean run after abort
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
